// File: rtl/teletext_packet_decoder.sv
// Teletext packet decoder: frames on clock run-in + framing code, Hamming 8/4 decodes MRAG,
// streams payload characters. Optional payload odd-parity checking enabled by PARITY_CHECK_EN.
module teletext_packet_decoder #(
    parameter int ROW_BYTES = 40
) (
    input  logic       read_clk,
    input  logic       reset,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_read_en,
    output logic [6:0] char_out,
    output logic [5:0] char_col,
    output logic [4:0] char_row,
    output logic [2:0] char_mag,
    output logic       char_valid,
    output logic       pkt_done,
    output logic       ham_err,
    output logic [7:0] parity_err_count
);

    localparam logic [1:0] HUNT  = 2'd0;
    localparam logic [1:0] MRAG1 = 2'd1;
    localparam logic [1:0] MRAG2 = 2'd2;
    localparam logic [1:0] DATA  = 2'd3;

    localparam logic [5:0] LAST_COL = 6'(ROW_BYTES - 1);

    logic [1:0] state;
    logic [1:0] match_cnt;
    logic [5:0] col;
    logic [2:0] mag_pend;
    logic       row0_pend;
    logic [4:0] row_lat;
    logic [2:0] mag_lat;
    logic       byte_valid;
    logic       run;

    logic       mrag_err;
    logic [3:0] nibble;
    logic [6:0] data_char;
    logic       parity_fail;

    // Syndrome decode: A/B/C are the three inverted-parity checks, D is whole-byte odd parity.
    // D failing means a single flip (correct it); D passing with a bad A/B/C means a double flip.
    function automatic logic [4:0] ham_decode(input logic [7:0] b);
        logic       chk_a;
        logic       chk_b;
        logic       chk_c;
        logic       chk_d;
        logic [2:0] syn;
        logic [3:0] n;
        chk_a = b[0] ^ b[1] ^ b[5] ^ b[7];
        chk_b = b[2] ^ b[1] ^ b[3] ^ b[7];
        chk_c = b[4] ^ b[1] ^ b[3] ^ b[5];
        chk_d = ^b;
        syn   = {~chk_c, ~chk_b, ~chk_a};
        n     = {b[7], b[5], b[3], b[1]};
        if (chk_d) begin
            ham_decode = {(syn != 3'b000), n};
        end else begin
            case (syn)
                3'b111:  n[0] = ~n[0];
                3'b110:  n[1] = ~n[1];
                3'b101:  n[2] = ~n[2];
                3'b011:  n[3] = ~n[3];
                default: n = n;
            endcase
            ham_decode = {1'b0, n};
        end
    endfunction

    always_comb begin
        {mrag_err, nibble} = ham_decode(fifo_data);
    end

`ifdef PARITY_CHECK_EN
    always_comb begin
        parity_fail = ~(^fifo_data);
        data_char   = parity_fail ? 7'h20 : fifo_data[6:0];
    end

    always_ff @(posedge read_clk or negedge reset) begin
        if (!reset) begin
            parity_err_count <= 8'd0;
        end else if (byte_valid && state == DATA && parity_fail && parity_err_count != 8'hFF) begin
            parity_err_count <= parity_err_count + 8'd1;
        end
    end
`else
    always_comb begin
        parity_fail = 1'b0;
        data_char   = fifo_data[6:0];
    end

    assign parity_err_count = 8'd0;
`endif

    // run holds pops off until the first edge after reset release.
    assign fifo_read_en = run & ~fifo_empty;

    always_ff @(posedge read_clk or negedge reset) begin
        if (!reset) begin
            state      <= HUNT;
            match_cnt  <= 2'd0;
            col        <= 6'd0;
            mag_pend   <= 3'd0;
            row0_pend  <= 1'b0;
            row_lat    <= 5'd0;
            mag_lat    <= 3'd0;
            byte_valid <= 1'b0;
            run        <= 1'b0;
            char_out   <= 7'd0;
            char_col   <= 6'd0;
            char_row   <= 5'd0;
            char_mag   <= 3'd0;
            char_valid <= 1'b0;
            pkt_done   <= 1'b0;
            ham_err    <= 1'b0;
        end else begin
            run        <= 1'b1;
            byte_valid <= fifo_read_en;
            char_valid <= 1'b0;
            pkt_done   <= 1'b0;
            ham_err    <= 1'b0;
            if (byte_valid) begin
                case (state)
                    HUNT: begin
                        if (match_cnt == 2'd2 && fifo_data == 8'h27) begin
                            match_cnt <= 2'd0;
                            state     <= MRAG1;
                        end else if (fifo_data == 8'h55) begin
                            if (match_cnt != 2'd2) begin
                                match_cnt <= match_cnt + 2'd1;
                            end
                        end else begin
                            match_cnt <= 2'd0;
                        end
                    end
                    MRAG1: begin
                        if (mrag_err) begin
                            ham_err <= 1'b1;
                            state   <= HUNT;
                        end else begin
                            mag_pend  <= nibble[2:0];
                            row0_pend <= nibble[3];
                            state     <= MRAG2;
                        end
                    end
                    MRAG2: begin
                        if (mrag_err) begin
                            ham_err <= 1'b1;
                            state   <= HUNT;
                        end else begin
                            row_lat <= {nibble, row0_pend};
                            mag_lat <= mag_pend;
                            col     <= 6'd0;
                            state   <= DATA;
                        end
                    end
                    default: begin
                        char_valid <= 1'b1;
                        char_out   <= data_char;
                        char_col   <= col;
                        char_row   <= row_lat;
                        char_mag   <= mag_lat;
                        if (col == LAST_COL) begin
                            pkt_done <= 1'b1;
                            col      <= 6'd0;
                            state    <= HUNT;
                        end else begin
                            col <= col + 6'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/teletext_packet_decoder.md
# teletext_packet_decoder

Consumes the byte stream popped from the teletext byte FIFO, running in the FIFO's read clock domain. Hunts for clock run-in plus framing code, then Hamming 8/4-decodes the two MRAG bytes to recover magazine and row. Emits the 40 payload characters with column/row/magazine addresses to the page-store writer downstream. No backpressure from downstream: every char_valid pulse is accepted.

## Interface
- ROW_BYTES, 40: payload bytes per packet; column counter is 6 bits, so values must be 1..64.
- read_clk  in  1  single clock; FIFO read-side clock.
- reset  in  1  asynchronous, active-low reset.
- fifo_data  in  8  FIFO read data; valid the cycle after a pop.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read_en  out  1  pop request.
- char_out  out  7  payload character.
- char_col  out  6  column 0..ROW_BYTES-1.
- char_row  out  5  packet row from MRAG.
- char_mag  out  3  magazine from MRAG; 0 means magazine 8.
- char_valid  out  1  one-cycle strobe qualifying char_out/col/row/mag.
- pkt_done  out  1  one-cycle pulse with the last char_valid of a packet.
- ham_err  out  1  one-cycle pulse on an uncorrectable MRAG byte.
- parity_err_count  out  8  saturating payload parity error count.

## Operation
- FIFO reads:
  - fifo_read_en is high in a cycle only if fifo_empty is low in that cycle.
  - Back-to-back pops are allowed.
  - A byte popped in cycle N is sampled from fifo_data in cycle N+1.
- State machine: HUNT -> MRAG1 -> MRAG2 -> DATA -> HUNT.
- HUNT:
  - Matches the consecutive sequence 0x55, 0x55, 0x27.
  - On mismatch, the match count restarts; a mismatching byte equal to 0x55 counts as the first match.
  - Extra 0x55 bytes keep the two-0x55 match, so 0x55,0x55,0x55,0x27 locks.
- Hamming 8/4:
  - Byte bits b0..b7 = P1,D1,P2,D2,P3,D3,P4,D4.
  - P1=~(D1^D3^D4), P2=~(D1^D2^D4), P3=~(D1^D2^D3), P4=~(P1^D1^P2^D2^P3^D3^D4).
  - Nibble = {D4,D3,D2,D1}.
  - Distance 0 from a codeword: accepted. Distance 1: corrected silently. Distance ≥2: error.
- MRAG1: nibble n1 gives mag=n1[2:0] and row[0]=n1[3].
- MRAG2: nibble n2 gives row[4:1]=n2.
- MRAG error: ham_err pulses; row and mag are not updated; next state is HUNT.
- DATA:
  - Each byte produces char_out=byte[6:0] and char_col=running column, starting at 0.
  - Row and mag are latched at MRAG2.
  - After ROW_BYTES characters, pkt_done pulses and the FSM returns to HUNT.
- No framing search inside DATA: a 0x55/0x27 in the payload is treated as a character.
- Reset (async assert):
  - State returns to HUNT; column counter and match count clear.
  - All outputs go to 0, including parity_err_count and fifo_read_en.
  - Any packet in flight is dropped; no partial pkt_done.

## Timing
- Latency: pop in cycle N, byte sampled in N+1, char_valid/ham_err/pkt_done registered high in N+2.
- Sustained rate is one character per cycle when the FIFO is non-empty.
- fifo_empty gaps stall the FSM with no state change; column numbering is unaffected.
- Release of reset takes effect on the first read_clk edge after deassertion; the first pop can occur in that cycle.

## Configuration
- PARITY_CHECK_EN defined:
  - Each DATA byte is checked for odd parity over all 8 bits.
  - A failing byte outputs char_out=0x20 (still with char_valid) and increments parity_err_count, saturating at 255.
- PARITY_CHECK_EN undefined:
  - No check is made; char_out=byte[6:0] always.
  - parity_err_count is tied to 0.

## Test plan
- Reset: assert reset low mid-idle -> all outputs 0; no fifo_read_en while fifo_empty=1.
- Clean packet: push 0x55,0x55,0x27,0x02,0x15 then 40×0xC1 -> 40 char_valid with char_out=0x41, col 0..39, mag=1, row=0; pkt_done on col 39; ham_err never pulses.
- Resync: push 0x12,0x55,0x55,0x55,0x27,0x02,0x15 plus payload -> lock acquired; decode as in the clean-packet case.
- Hamming: MRAG1=0x03 -> corrected to mag=1. MRAG1=0x07 -> ham_err pulse, no char_valid, FSM in HUNT; the next clean packet decodes.
- Parity: payload byte 0x41 -> with PARITY_CHECK_EN, char_out=0x20 and parity_err_count=1; without it, char_out=0x41 and parity_err_count=0.
- Reset mid-packet at col 20, then a full packet with fifo_empty toggling every other cycle -> new packet reported from col 0; no pop while empty; exactly one pkt_done.
